bimpy_seq_mult: RTL and testbench
=================================

Name: bimpy_seq_mult

Overview:
Iterative signed multiplier controller built around a 2xN partial-product datapath. It accepts one operand pair over a valid/ready handshake and converts both operands to magnitudes. It then walks the multiplier two bits per cycle, accumulating (digit × |B|) shifted by 2·k, and finally restores the sign. It is used in the FFT's low-rate paths (twiddle setup, scaling), where area matters more than throughput and a full-width multiplier is not justified.

Parameters:
IAW, 8, multiplier (i_a) width in bits; must be even and ≥2
IBW, 12, multiplicand (i_b) width in bits; ≥2
OW, IAW+IBW, result width (derived; do not override)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_abort  in  1  synchronous abort; returns to IDLE and discards any operation
i_in_valid  in  1  operand pair valid
o_in_ready  out  1  block can accept operands (high only in IDLE)
i_a  in  IAW  signed two's-complement multiplier
i_b  in  IBW  signed two's-complement multiplicand
o_out_valid  out  1  o_r holds a valid product
i_out_ready  in  1  consumer accepts o_r
o_r  out  OW  signed product i_a × i_b
o_busy  out  1  high in RUN or DONE

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (i_reset_n=0) forces the following immediately, regardless of state: state=IDLE, o_in_ready=1, o_out_valid=0, o_busy=0, o_r=0, accumulator=0, digit counter=0.
- NDIG = IAW/2. Counter width is clog2(NDIG)+1.
- States and transitions:
  - IDLE → RUN when i_in_valid && o_in_ready.
    - On that edge, latch |i_a| into an IAW-bit unsigned shift register and |i_b| into an IBW-bit unsigned register.
    - Latch neg = i_a[IAW-1] ^ i_b[IBW-1].
    - Clear the accumulator and the counter.
  - RUN, one cycle per digit:
    - partial = a_sr[1:0] × b_mag. This is IBW+2 bits, computed combinationally as (a1 ? b<<1 : 0) + (a0 ? b : 0).
    - acc += partial << (2·cnt). The accumulator is OW bits, unsigned.
    - a_sr >>= 2; cnt++.
    - On the cycle with cnt==NDIG-1, the edge writes o_r = neg ? −(acc+partial<<2cnt) : (acc+partial<<2cnt), truncated to OW bits. State → DONE.
  - DONE: o_out_valid=1 and o_r is held stable. On i_out_ready, state → IDLE and o_out_valid drops on that edge.
- Latency: operands accepted at edge 0; o_out_valid is high from cycle NDIG+1.
- Throughput: one product per NDIG+2 cycles with i_out_ready tied high.
- o_in_ready = (state==IDLE). Operands presented while not ready are ignored, not queued.
- Magnitude rules:
  - |−2^(IAW-1)| = 2^(IAW-1) fits unsigned IAW bits; likewise for B.
  - The worst case (−2^(IAW-1)) × (−2^(IBW-1)) = 2^(OW-2) fits signed OW bits, so there is no overflow.
- Zero operand: result 0 with no negative zero. neg is ignored when the magnitude is 0.
- i_abort:
  - Has priority over all transitions.
  - Forces IDLE, o_out_valid=0, acc=0, cnt=0.
  - o_r keeps its last value but is not valid.
  - Abort while in IDLE is a no-op, and any simultaneous i_in_valid is not accepted.
- Reset mid-operation: the operation is lost and no o_out_valid is produced.
- Back-pressure: DONE may persist indefinitely, and o_r and o_out_valid must not change while i_out_ready=0.
- Early termination: RUN always takes exactly NDIG cycles, even if the remaining a_sr bits are zero (fixed latency).

Test Plan:
- IAW=8, IBW=12, i_out_ready=1; a=5, b=7 accepted at edge 0 → o_out_valid first high in cycle 5 with o_r=35; o_in_ready low during cycles 1–5 and high again in cycle 6.
- a=−128, b=−2048 → o_r=262144 (0x40000). Also a=−3, b=100 → o_r=−300 (0xFFED4). Also a=0, b=−2048 → o_r=0.
- a=127, b=2047 with i_out_ready=0 for 10 cycles after o_out_valid rises → o_r=259969 held constant with o_out_valid=1 throughout; completes one cycle after i_out_ready=1.
- i_in_valid held high with new operands every cycle during RUN → only the first pair is multiplied and the next is accepted in the first IDLE cycle. Back-to-back products arrive every 6 cycles.
- i_abort pulsed in RUN cycle 2 → no o_out_valid; o_in_ready=1 next cycle; the following operation (a=−1, b=−1) yields o_r=1, unaffected by stale accumulator state.
- i_reset_n dropped asynchronously mid-RUN and in DONE → all outputs take their reset values immediately (o_r=0, o_out_valid=0, o_in_ready=1); normal operation resumes after release.

Source files
------------

// File: rtl/bimpy_seq_mult.sv
// bimpy_seq_mult: iterative signed multiplier retiring two multiplier bits per cycle over |a| and |b|
module bimpy_seq_mult #(
  parameter int IAW = 8,
  parameter int IBW = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_abort,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [IAW-1:0]       i_a,
  input  logic [IBW-1:0]       i_b,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [IAW+IBW-1:0]   o_r,
  output logic                 o_busy
);
  localparam int OW = IAW + IBW;
  localparam int NDIG = IAW / 2;
  localparam int CW = $clog2(NDIG) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IAW-1:0] a_sr;
  logic [IBW-1:0] b_mag;
  logic neg;
  logic [OW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [IBW+1:0] partial;
  logic last, accept;
  assign partial = (a_sr[1] ? {1'b0, b_mag, 1'b0} : '0) + (a_sr[0] ? {2'b00, b_mag} : '0);
  assign sum = acc + (OW'(partial) << {cnt, 1'b0});
  assign last = cnt == CW'(NDIG - 1);
  assign accept = state == IDLE && i_in_valid && !i_abort;
  assign o_in_ready = state == IDLE;
  assign o_out_valid = state == DONE;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (i_abort) state_n = IDLE;
    else if (accept) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE && i_out_ready) state_n = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_n;
  // negating a zero magnitude yields zero, so no negative-zero special case is needed
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      a_sr <= '0;
      b_mag <= '0;
      neg <= 1'b0;
      acc <= '0;
      cnt <= '0;
      o_r <= '0;
    end else if (i_abort) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      a_sr <= i_a[IAW-1] ? -i_a : i_a;
      b_mag <= i_b[IBW-1] ? -i_b : i_b;
      neg <= i_a[IAW-1] ^ i_b[IBW-1];
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= sum;
      a_sr <= a_sr >> 2;
      cnt <= cnt + CW'(1);
      if (last) o_r <= neg ? -sum : sum;
    end
endmodule

// File: tb/tb_bimpy_seq_mult.sv
// tb_bimpy_seq_mult: scoreboard bench comparing products against signed integer multiplication
module tb_bimpy_seq_mult;
  logic i_clk = 0, i_reset_n = 0, i_abort = 0, i_in_valid = 0, i_out_ready = 1;
  logic [7:0] i_a = '0;
  logic [11:0] i_b = '0;
  logic o_in_ready, o_out_valid, o_busy;
  logic [19:0] o_r;
  int pass_cnt = 0, chk_cnt = 0, cyc = 0, prev_cyc = 0;
  logic [19:0] exp_q[$];
  logic [19:0] held;
  logic hold = 0, rnd_rdy = 0, stream_mode = 0, have_prev = 0;

  bimpy_seq_mult #(.IAW(8), .IBW(12)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_abort(i_abort), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_a(i_a), .i_b(i_b), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_r(o_r), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
  endfunction

  // reference model: the product of the operands as signed integers, truncated to 20 bits
  always @(posedge i_clk) begin
    cyc++;
    if (i_reset_n && i_abort && o_busy) exp_q.delete();
    if (i_reset_n && i_in_valid && o_in_ready && !i_abort)
      exp_q.push_back(20'(int'($signed(i_a)) * int'($signed(i_b))));
  end

  always @(negedge i_reset_n) begin
    exp_q.delete();
    hold = 0;
  end

  always @(negedge i_clk) begin
    if (i_reset_n && o_out_valid) begin
      if (hold) check("held_r", o_r, held);
      if (i_out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("product", o_r, exp_q.pop_front());
        if (stream_mode && have_prev) check("stream_period", cyc - prev_cyc, 6);
        prev_cyc = cyc;
        have_prev = 1;
      end
      hold = !i_out_ready;
      held = o_r;
    end else begin
      if (i_reset_n && hold) check("held_valid", o_out_valid, 1);
      hold = 0;
    end
  end

  always begin
    @(posedge i_clk);
    #1;
    if (rnd_rdy) i_out_ready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [11:0] b);
    int n = 0;
    logic ok;
    i_a = a;
    i_b = b;
    i_in_valid = 1;
    do begin
      ok = o_in_ready;
      step();
      n++;
    end while (!ok && n < 300);
    i_in_valid = 0;
    if (!ok) check("issue_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !o_in_ready) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("drain_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_out_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_ready"}, o_in_ready, 1);
    check({tag, "_valid"}, o_out_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_r"}, o_r, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_reset_outs("reset");
    #20;
    i_reset_n = 1;
    step();
    issue(8'd5, 12'd7);
    for (int k = 1; k <= 5; k++) begin
      check("lat_ready", o_in_ready, 0);
      check("lat_valid", o_out_valid, 32'(k == 5));
      step();
    end
    check("lat_ready_back", o_in_ready, 1);
    issue(-8'sd128, -12'sd2048);
    issue(-8'sd3, 12'd100);
    issue(8'd0, -12'sd2048);
    issue(-8'sd128, 12'd2047);
    issue(8'd127, -12'sd2048);
    issue(-8'sd1, -12'sd1);
    drain();
    i_out_ready = 0;
    issue(8'd127, 12'd2047);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", o_out_valid, 1);
      check("bp_r", o_r, 259969);
      step();
    end
    i_out_ready = 1;
    step();
    check("bp_release", o_out_valid, 0);
    stream_mode = 1;
    have_prev = 0;
    i_in_valid = 1;
    for (int k = 0; k < 30; k++) begin
      i_a = 8'($urandom);
      i_b = 12'($urandom);
      step();
    end
    i_in_valid = 0;
    drain();
    stream_mode = 0;
    issue(8'd9, 12'd9);
    step();
    i_abort = 1;
    step();
    i_abort = 0;
    check("abort_ready", o_in_ready, 1);
    check("abort_valid", o_out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      check("abort_no_out", o_out_valid, 0);
      step();
    end
    issue(-8'sd1, -12'sd1);
    drain();
    i_abort = 1;
    i_in_valid = 1;
    step();
    i_abort = 0;
    i_in_valid = 0;
    check("abort_idle_ready", o_in_ready, 1);
    check("abort_idle_busy", o_busy, 0);
    issue(8'd3, 12'd4);
    @(posedge i_clk);
    #3;
    i_reset_n = 0;
    #1;
    check_reset_outs("rst_run");
    @(posedge i_clk);
    #3;
    i_reset_n = 1;
    step();
    i_out_ready = 0;
    issue(8'd11, 12'd13);
    wait_valid();
    #2;
    i_reset_n = 0;
    #1;
    check_reset_outs("rst_done");
    @(posedge i_clk);
    #3;
    i_reset_n = 1;
    i_out_ready = 1;
    step();
    issue(-8'sd5, 12'd3);
    drain();
    rnd_rdy = 1;
    for (int k = 0; k < 40; k++) issue(8'($urandom), 12'($urandom));
    drain();
    rnd_rdy = 0;
    step();
    i_out_ready = 1;
    drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
